// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the LSU memory stage.
//   - state_t       : stage FSM states (IDLE / MEM / OUT)
//   - WIDTH         : data/address width (only 32 is supported)
//   - F3_*          : funct3 encodings for loads and stores
//   - is_misaligned : natural-alignment test used when LSU_MISALIGN_CHECK_EN is defined
package lsu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Stores share the load encodings for H and W, so one table covers both.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_LH, F3_LHU: return addr_lo[0];
            F3_LW:         return addr_lo != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: single-outstanding request/response data bus.
//   master (LSU)   : drives mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
//   slave (memory) : drives mem_rvalid (read data valid / write ack), mem_rdata
interface lsu_mem_stage_if;
    import lsu_pkg::*;

    logic             mem_req;
    logic             mem_wen;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_wmask;
    logic             mem_rvalid;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational store shaping and load extraction.
//   funct3, addr_lo  : access size/sign and the low two address bits
//   store_data       : raw rs2 value -> wdata (lane-replicated), wmask
//   rdata            : raw bus word  -> load_data (shifted, sign/zero-extended)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] wdata,
    output logic [3:0]       wmask,
    output logic [WIDTH-1:0] load_data
);

    logic [WIDTH-1:0] shifted;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wdata = store_data;
        wmask = 4'b1111;
        case (funct3)
            F3_SB: begin
                wdata = {4{store_data[7:0]}};
                wmask = 4'b0001 << addr_lo;
            end
            F3_SH: begin
                wdata = {2{store_data[15:0]}};
                wmask = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Bring the addressed byte to lane 0; bytes past the word end are lost.
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage between EXU and writeback.
//   clk, rst          : clock, asynchronous active-high reset
//   exu_*             : incoming bundle (valid/ready handshake with lsu_ready)
//   lsu_*             : outgoing writeback bundle (valid/ready with wbu_ready)
//   mem               : data bus master port (lsu_mem_stage_if.master)
// Build option: LSU_MISALIGN_CHECK_EN - misaligned H/W accesses skip the bus and
// retire with lsu_misalign=1 and rd_we=0; undefined ties lsu_misalign to 0.
module lsu_mem_stage
    import lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  lsu_ready,
    input  logic [WIDTH-1:0]      exu_pc,
    input  logic [WIDTH-1:0]      exu_result,
    input  logic [WIDTH-1:0]      exu_store_data,
    input  logic                  exu_mem_ren,
    input  logic                  exu_mem_wen,
    input  logic [2:0]            exu_funct3,
    input  logic [4:0]            exu_rd_addr,
    input  logic                  exu_rd_we,
    output logic                  lsu_valid,
    input  logic                  wbu_ready,
    output logic [WIDTH-1:0]      lsu_pc,
    output logic [4:0]            lsu_rd_addr,
    output logic                  lsu_rd_we,
    output logic [WIDTH-1:0]      lsu_rd_data,
    output logic                  lsu_misalign,
    lsu_mem_stage_if.master       mem
);

    state_t           state, state_next;
    logic [WIDTH-1:0] pc_q, rd_data_q, addr_q, sdata_q;
    logic [4:0]       rd_addr_q;
    logic [2:0]       funct3_q;
    logic             rd_we_q, store_q, misalign_q;
    logic             transfer, mem_op, acc_misalign, in_mem;
    logic [WIDTH-1:0] wdata, load_data;
    logic [3:0]       wmask;

    assign transfer = exu_valid && (state == IDLE);
    assign mem_op   = exu_mem_ren || exu_mem_wen;

`ifdef LSU_MISALIGN_CHECK_EN
    assign acc_misalign = mem_op && is_misaligned(exu_funct3, exu_result[1:0]);
`else
    assign acc_misalign = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (transfer) state_next = (mem_op && !acc_misalign) ? MEM : OUT;
            MEM:     if (mem.mem_rvalid) state_next = OUT;
            OUT:     if (wbu_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            rd_data_q  <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            funct3_q   <= '0;
            store_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (transfer) begin
            pc_q       <= exu_pc;
            rd_addr_q  <= exu_rd_addr;
            addr_q     <= exu_result;
            sdata_q    <= exu_store_data;
            funct3_q   <= exu_funct3;
            store_q    <= exu_mem_wen;
            misalign_q <= acc_misalign;
            rd_we_q    <= exu_rd_we && !acc_misalign;
            rd_data_q  <= mem_op ? '0 : exu_result;
        end else if (state == MEM && mem.mem_rvalid) begin
            // A store retires with no register write.
            rd_data_q <= store_q ? '0 : load_data;
            if (store_q) rd_we_q <= 1'b0;
        end
    end

    lsu_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (mem.mem_rdata),
        .wdata      (wdata),
        .wmask      (wmask),
        .load_data  (load_data)
    );

    // Bus outputs are qualified by MEM so they read 0 whenever no request is pending.
    assign in_mem        = (state == MEM);
    assign mem.mem_req   = in_mem;
    assign mem.mem_wen   = in_mem && store_q;
    assign mem.mem_addr  = in_mem ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign mem.mem_wdata = (in_mem && store_q) ? wdata : '0;
    assign mem.mem_wmask = (in_mem && store_q) ? wmask : 4'b0000;

    assign lsu_ready    = (state == IDLE);
    assign lsu_valid    = (state == OUT);
    assign lsu_pc       = pc_q;
    assign lsu_rd_addr  = rd_addr_q;
    assign lsu_rd_we    = rd_we_q;
    assign lsu_rd_data  = rd_data_q;
    assign lsu_misalign = misalign_q && (state == OUT);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_ready;
    logic [31:0] exu_pc, exu_result, exu_store_data;
    logic        exu_mem_ren, exu_mem_wen;
    logic [2:0]  exu_funct3;
    logic [4:0]  exu_rd_addr;
    logic        exu_rd_we;
    logic        lsu_valid, wbu_ready;
    logic [31:0] lsu_pc, lsu_rd_data;
    logic [4:0]  lsu_rd_addr;
    logic        lsu_rd_we, lsu_misalign;

    int passed = 0;
    int total  = 0;

    lsu_mem_stage_if bus ();

    lsu_mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .exu_valid      (exu_valid),
        .lsu_ready      (lsu_ready),
        .exu_pc         (exu_pc),
        .exu_result     (exu_result),
        .exu_store_data (exu_store_data),
        .exu_mem_ren    (exu_mem_ren),
        .exu_mem_wen    (exu_mem_wen),
        .exu_funct3     (exu_funct3),
        .exu_rd_addr    (exu_rd_addr),
        .exu_rd_we      (exu_rd_we),
        .lsu_valid      (lsu_valid),
        .wbu_ready      (wbu_ready),
        .lsu_pc         (lsu_pc),
        .lsu_rd_addr    (lsu_rd_addr),
        .lsu_rd_we      (lsu_rd_we),
        .lsu_rd_data    (lsu_rd_data),
        .lsu_misalign   (lsu_misalign),
        .mem            (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one bundle for exactly one cycle (stage must be in IDLE).
    task automatic drive_op(input logic ren, input logic wen, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] pc, input logic [4:0] rd, input logic we);
        exu_valid      = 1'b1;
        exu_mem_ren    = ren;
        exu_mem_wen    = wen;
        exu_funct3     = f3;
        exu_result     = addr;
        exu_store_data = sdata;
        exu_pc         = pc;
        exu_rd_addr    = rd;
        exu_rd_we      = we;
        tick();
        exu_valid = 1'b0;
    endtask

    // Zero-wait response in the current MEM cycle.
    task automatic respond(input logic [31:0] rdata);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        exu_valid = 0; exu_mem_ren = 0; exu_mem_wen = 0; exu_funct3 = 0;
        exu_pc = 0; exu_result = 0; exu_store_data = 0; exu_rd_addr = 0; exu_rd_we = 0;
        wbu_ready = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        tick(); tick();
        total++; if ({lsu_valid, bus.mem_req, bus.mem_wen, lsu_rd_we, lsu_misalign} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {lsu_valid, bus.mem_req, bus.mem_wen, lsu_rd_we, lsu_misalign}); else passed++;
        total++; if ({lsu_rd_data, lsu_pc, bus.mem_addr, bus.mem_wdata} !== 128'h0) $display("FAIL reset_data: got %h want 0", {lsu_rd_data, lsu_pc, bus.mem_addr, bus.mem_wdata}); else passed++;
        total++; if (bus.mem_wmask !== 4'b0000) $display("FAIL reset_wmask: got %b want 0000", bus.mem_wmask); else passed++;
        rst = 1'b0;
        tick();
        total++; if (lsu_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", lsu_ready); else passed++;
    endtask

    task automatic test_passthrough();
        drive_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_0040, 5'd5, 1'b1);
        total++; if (lsu_valid !== 1'b1) $display("FAIL pass_valid: got %b want 1", lsu_valid); else passed++;
        total++; if (lsu_rd_data !== 32'h0000_1234) $display("FAIL pass_data: got %h want 00001234", lsu_rd_data); else passed++;
        total++; if ({lsu_rd_addr, lsu_rd_we} !== {5'd5, 1'b1}) $display("FAIL pass_rd: got %0d/%b want 5/1", lsu_rd_addr, lsu_rd_we); else passed++;
        total++; if (lsu_pc !== 32'h0000_0040) $display("FAIL pass_pc: got %h want 00000040", lsu_pc); else passed++;
        total++; if ({bus.mem_req, lsu_ready} !== 2'b00) $display("FAIL pass_req_ready: got %b want 00", {bus.mem_req, lsu_ready}); else passed++;
        tick();
        total++; if ({lsu_valid, lsu_ready, bus.mem_req} !== 3'b010) $display("FAIL pass_retire: got %b want 010", {lsu_valid, lsu_ready, bus.mem_req}); else passed++;
    endtask

    task automatic test_loads();
        // LB at 0x80000003: top byte 0x80 sign-extends.
        drive_op(1'b1, 1'b0, F3_LB, 32'h8000_0003, 32'h0, 32'h0000_0100, 5'd3, 1'b1);
        total++; if ({bus.mem_req, bus.mem_wen} !== 2'b10) $display("FAIL lb_req: got %b want 10", {bus.mem_req, bus.mem_wen}); else passed++;
        total++; if (bus.mem_addr !== 32'h8000_0000) $display("FAIL lb_addr: got %h want 80000000", bus.mem_addr); else passed++;
        total++; if (lsu_valid !== 1'b0) $display("FAIL lb_early_valid: got %b want 0", lsu_valid); else passed++;
        respond(32'h80FF_7F00);
        total++; if ({lsu_valid, bus.mem_req} !== 2'b10) $display("FAIL lb_valid: got %b want 10", {lsu_valid, bus.mem_req}); else passed++;
        total++; if (lsu_rd_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", lsu_rd_data); else passed++;
        total++; if ({lsu_rd_addr, lsu_rd_we} !== {5'd3, 1'b1}) $display("FAIL lb_rd: got %0d/%b want 3/1", lsu_rd_addr, lsu_rd_we); else passed++;
        tick();
        drive_op(1'b1, 1'b0, F3_LBU, 32'h8000_0003, 32'h0, 32'h0000_0104, 5'd4, 1'b1);
        respond(32'h80FF_7F00);
        total++; if (lsu_rd_data !== 32'h0000_0080) $display("FAIL lbu_data: got %h want 00000080", lsu_rd_data); else passed++;
        tick();
        // Halfword loads from the upper half: 0x80FF.
        drive_op(1'b1, 1'b0, F3_LH, 32'h8000_0002, 32'h0, 32'h0000_0108, 5'd6, 1'b1);
        respond(32'h80FF_7F00);
        total++; if (lsu_rd_data !== 32'hFFFF_80FF) $display("FAIL lh_data: got %h want ffff80ff", lsu_rd_data); else passed++;
        tick();
        drive_op(1'b1, 1'b0, F3_LHU, 32'h8000_0002, 32'h0, 32'h0000_010C, 5'd6, 1'b1);
        respond(32'h80FF_7F00);
        total++; if (lsu_rd_data !== 32'h0000_80FF) $display("FAIL lhu_data: got %h want 000080ff", lsu_rd_data); else passed++;
        tick();
    endtask

    task automatic test_stores();
        drive_op(1'b0, 1'b1, F3_SH, 32'h8000_0002, 32'h0000_ABCD, 32'h0000_0200, 5'd8, 1'b1);
        total++; if ({bus.mem_req, bus.mem_wen} !== 2'b11) $display("FAIL sh_req: got %b want 11", {bus.mem_req, bus.mem_wen}); else passed++;
        total++; if (bus.mem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h want abcdabcd", bus.mem_wdata); else passed++;
        total++; if (bus.mem_wmask !== 4'b1100) $display("FAIL sh_wmask: got %b want 1100", bus.mem_wmask); else passed++;
        total++; if (bus.mem_addr !== 32'h8000_0000) $display("FAIL sh_addr: got %h want 80000000", bus.mem_addr); else passed++;
        respond(32'h1234_5678);
        total++; if ({lsu_valid, lsu_rd_we} !== 2'b10) $display("FAIL sh_retire: got %b want 10", {lsu_valid, lsu_rd_we}); else passed++;
        total++; if (lsu_rd_data !== 32'h0) $display("FAIL sh_data: got %h want 0", lsu_rd_data); else passed++;
        tick();
        drive_op(1'b0, 1'b1, F3_SB, 32'h8000_0001, 32'h1234_5678, 32'h0000_0204, 5'd8, 1'b1);
        total++; if ({bus.mem_wdata, bus.mem_wmask} !== {32'h7878_7878, 4'b0010}) $display("FAIL sb_shape: got %h/%b want 78787878/0010", bus.mem_wdata, bus.mem_wmask); else passed++;
        respond(32'h0);
        tick();
        drive_op(1'b0, 1'b1, F3_SW, 32'h8000_0004, 32'hA5A5_0F0F, 32'h0000_0208, 5'd8, 1'b1);
        total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== {32'h8000_0004, 32'hA5A5_0F0F, 4'b1111}) $display("FAIL sw_shape: got %h/%h/%b want 80000004/a5a50f0f/1111", bus.mem_addr, bus.mem_wdata, bus.mem_wmask); else passed++;
        respond(32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        int held = 0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        drive_op(1'b1, 1'b0, F3_LW, 32'h8000_0010, 32'h0, 32'h0000_0300, 5'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h8000_0010 && bus.mem_wen === 1'b0 && lsu_valid === 1'b0) held++;
            if (i == 3) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hCAFE_F00D;
            end
            tick();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        total++; if (held !== 4) $display("FAIL lw_req_held: got %0d cycles want 4", held); else passed++;
        // Stall WB for three cycles while EXU offers the next bundle.
        wbu_ready      = 1'b0;
        exu_valid      = 1'b1;
        exu_mem_ren    = 1'b0;
        exu_mem_wen    = 1'b0;
        exu_result     = 32'h0000_0055;
        exu_pc         = 32'h0000_0304;
        exu_rd_addr    = 5'd9;
        exu_rd_we      = 1'b1;
        held = 0;
        for (int i = 0; i < 3; i++) begin
            if (lsu_valid === 1'b1 && lsu_rd_data === 32'hCAFE_F00D && lsu_rd_addr === 5'd7 && lsu_pc === 32'h0000_0300 && lsu_ready === 1'b0 && bus.mem_req === 1'b0) held++;
            tick();
        end
        total++; if (held !== 3) $display("FAIL stall_stable: got %0d good cycles want 3", held); else passed++;
        wbu_ready = 1'b1;
        tick();
        total++; if ({lsu_valid, lsu_ready} !== 2'b01) $display("FAIL stall_handshake: got %b want 01", {lsu_valid, lsu_ready}); else passed++;
        tick();
        exu_valid = 1'b0;
        total++; if ({lsu_valid, lsu_rd_data, lsu_rd_addr} !== {1'b1, 32'h0000_0055, 5'd9}) $display("FAIL next_bundle: got %b/%h/%0d want 1/00000055/9", lsu_valid, lsu_rd_data, lsu_rd_addr); else passed++;
        tick();
    endtask

    task automatic test_reset_in_mem();
        drive_op(1'b1, 1'b0, F3_LW, 32'h8000_0020, 32'h0, 32'h0000_0400, 5'd10, 1'b1);
        total++; if (bus.mem_req !== 1'b1) $display("FAIL rmem_req: got %b want 1", bus.mem_req); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL rmem_drop: got %b want 0", bus.mem_req); else passed++;
        tick();
        rst = 1'b0;
        tick(); tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        tick();
        bus.mem_rvalid = 1'b0;
        total++; if ({lsu_valid, lsu_ready, bus.mem_req} !== 3'b010) $display("FAIL rmem_late_rvalid: got %b want 010", {lsu_valid, lsu_ready, bus.mem_req}); else passed++;
        tick();
        total++; if ({lsu_valid, lsu_ready} !== 2'b01) $display("FAIL rmem_idle: got %b want 01", {lsu_valid, lsu_ready}); else passed++;
    endtask

    task automatic test_misalign();
        drive_op(1'b1, 1'b0, F3_LW, 32'h8000_0002, 32'h0, 32'h0000_0500, 5'd11, 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
        total++; if (bus.mem_req !== 1'b0) $display("FAIL mis_noreq: got %b want 0", bus.mem_req); else passed++;
        total++; if ({lsu_valid, lsu_misalign, lsu_rd_we} !== 3'b110) $display("FAIL mis_flag: got %b want 110", {lsu_valid, lsu_misalign, lsu_rd_we}); else passed++;
        tick();
`else
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h8000_0000}) $display("FAIL mis_bus: got %b/%h want 1/80000000", bus.mem_req, bus.mem_addr); else passed++;
        respond(32'h1122_3344);
        total++; if ({lsu_valid, lsu_misalign, lsu_rd_we} !== 3'b101) $display("FAIL mis_flag: got %b want 101", {lsu_valid, lsu_misalign, lsu_rd_we}); else passed++;
        total++; if (lsu_rd_data !== 32'h0000_1122) $display("FAIL mis_data: got %h want 00001122", lsu_rd_data); else passed++;
        tick();
`endif
        total++; if ({lsu_valid, lsu_ready} !== 2'b01) $display("FAIL mis_retire: got %b want 01", {lsu_valid, lsu_ready}); else passed++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_back_to_back();
        test_reset_in_mem();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
